// File: rtl/tcs3200_color_classifier.sv
// TCS3200 front end: steps the R/G/B filters, counts sensor edges per gate window and classifies the dominant colour.
// Result latency 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles after leaving IDLE; no backpressure, the sensor input is free-running.
module tcs3200_color_classifier #(
  parameter int GATE_CYCLES   = 4000,
  parameter int SETTLE_CYCLES = 80,
  parameter int CNT_W         = 12,
  parameter int MIN_COUNT     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sensor_out,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic [1:0]       color,
  output logic             color_valid,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SET_R  = 3'd1;
  localparam logic [2:0] GATE_R = 3'd2;
  localparam logic [2:0] SET_G  = 3'd3;
  localparam logic [2:0] GATE_G = 3'd4;
  localparam logic [2:0] SET_B  = 3'd5;
  localparam logic [2:0] GATE_B = 3'd6;
  localparam logic [2:0] DECIDE = 3'd7;

  localparam logic [1:0] COLOR_NONE  = 2'b00;
  localparam logic [1:0] COLOR_RED   = 2'b01;
  localparam logic [1:0] COLOR_BLUE  = 2'b10;
  localparam logic [1:0] COLOR_GREEN = 2'b11;

  logic             sync1;
  logic             sync2;
  logic             sync3;
  logic             edge_pulse;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [TMR_W-1:0] timer;
  logic             timer_done;
  logic [CNT_W-1:0] work_r;
  logic [CNT_W-1:0] work_g;
  logic [CNT_W-1:0] work_b;
  logic [CNT_W-1:0] max_cnt;
  logic [1:0]       n_max;
  logic [1:0]       color_nxt;

  // 20% output scaling is fixed for this board.
  assign s0 = 1'b1;
  assign s1 = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sensor_out;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_pulse = sync2 & ~sync3;

  always_comb begin
    timer_done = 1'b0;
    case (state)
      SET_R, SET_G, SET_B:    timer_done = (timer == SETTLE_LAST);
      GATE_R, GATE_G, GATE_B: timer_done = (timer == GATE_LAST);
      default:                timer_done = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SET_R;
      SET_R:   if (timer_done) state_nxt = GATE_R;
      GATE_R:  if (timer_done) state_nxt = SET_G;
      SET_G:   if (timer_done) state_nxt = GATE_G;
      GATE_G:  if (timer_done) state_nxt = SET_B;
      SET_B:   if (timer_done) state_nxt = GATE_B;
      GATE_B:  if (timer_done) state_nxt = DECIDE;
      DECIDE:  state_nxt = enable ? SET_R : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Dropping enable abandons a measurement in progress; DECIDE always completes.
    if (!enable && state != IDLE && state != DECIDE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) timer <= '0;
      else                                     timer <= timer + 1'b1;
    end
  end

  always_comb begin
    s2 = 1'b0;
    s3 = 1'b0;
    case (state)
      SET_G, GATE_G:         begin s2 = 1'b1; s3 = 1'b1; end
      SET_B, GATE_B, DECIDE: begin s2 = 1'b0; s3 = 1'b1; end
      default:               begin s2 = 1'b0; s3 = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r <= '0;
      work_g <= '0;
      work_b <= '0;
    end else begin
      case (state)
        SET_R:   work_r <= '0;
        SET_G:   work_g <= '0;
        SET_B:   work_b <= '0;
        GATE_R:  if (edge_pulse && work_r != CNT_MAX) work_r <= work_r + 1'b1;
        GATE_G:  if (edge_pulse && work_g != CNT_MAX) work_g <= work_g + 1'b1;
        GATE_B:  if (edge_pulse && work_b != CNT_MAX) work_b <= work_b + 1'b1;
        default: ;
      endcase
    end
  end

  // A saturated count is an ordinary value here, so two saturated channels tie.
  always_comb begin
    max_cnt = work_r;
    if (work_g > max_cnt) max_cnt = work_g;
    if (work_b > max_cnt) max_cnt = work_b;
    n_max = 2'(work_r == max_cnt) + 2'(work_g == max_cnt) + 2'(work_b == max_cnt);
    color_nxt = COLOR_NONE;
    if (int'(max_cnt) >= MIN_COUNT && n_max == 2'd1) begin
      if (work_r == max_cnt)      color_nxt = COLOR_RED;
      else if (work_g == max_cnt) color_nxt = COLOR_GREEN;
      else                        color_nxt = COLOR_BLUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color       <= COLOR_NONE;
      color_valid <= 1'b0;
      red_cnt     <= '0;
      green_cnt   <= '0;
      blue_cnt    <= '0;
    end else begin
      color_valid <= (state == DECIDE);
      if (state == DECIDE) begin
        color     <= color_nxt;
        red_cnt   <= work_r;
        green_cnt <= work_g;
        blue_cnt  <= work_b;
      end
    end
  end

endmodule

// File: doc/tcs3200_color_classifier.md
Name: tcs3200_color_classifier

Overview:
- Upstream stage of the bot's RGB LED indicator. Drives the TCS3200 colour sensor's filter-select pins and counts sensor output edges per filter over a fixed gate window.
- Classifies the dominant colour into the 2-bit code the LED indicator consumes: 00 none/init, 01 red, 10 blue, 11 green.
- Runs on the 800 kHz system clock.

Parameters:
- GATE_CYCLES, 4000, length of the counting window per filter in clk cycles (5 ms at 800 kHz).
- SETTLE_CYCLES, 80, wait after each filter switch before counting starts.
- CNT_W, 12, width of each channel counter; counters saturate at 2^CNT_W-1.
- MIN_COUNT, 20, the winning channel count must be >= this, otherwise the result is 00.

Ports:
- clk  in  1  800 kHz system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  high = measure continuously; low = finish nothing, return to IDLE
- sensor_out  in  1  TCS3200 OUT pin, asynchronous square wave
- s0  out  1  frequency scaling select, constant 1
- s1  out  1  frequency scaling select, constant 0 (20% scaling)
- s2  out  1  filter select bit (red 0,0; blue 0,1; green 1,1, as s2,s3)
- s3  out  1  filter select bit
- color  out  2  last classified colour, held between measurements
- color_valid  out  1  one-cycle pulse when a measurement completes
- red_cnt, green_cnt, blue_cnt  out  CNT_W each  last completed counts (debug)

Behaviour:
- Reset (async, rst_n low): state IDLE; color=00; color_valid=0; s2=0, s3=0; all counts 0; s0=1, s1=0 at all times.
- Input conditioning: sensor_out passes through a 2-FF synchroniser, then rising-edge detect (1-cycle pulse). Synchroniser reset to 0.
- FSM states: IDLE, SET_R, GATE_R, SET_G, GATE_G, SET_B, GATE_B, DECIDE.
- IDLE: s2,s3=00. When enable=1, go to SET_R next cycle.
- SET_x: drive filter bits for channel x; stay exactly SETTLE_CYCLES cycles; clear channel x's working counter on entry; no counting.
- GATE_x: filter bits held; stay exactly GATE_CYCLES cycles; each edge pulse in a GATE_x cycle increments the working counter, saturating.
- Sequence: SET_R→GATE_R→SET_G→GATE_G→SET_B→GATE_B→DECIDE.
- DECIDE (1 cycle): copy working counts to red/green/blue_cnt; classify; register color; pulse color_valid next cycle. Then go to SET_R if enable=1, else IDLE.
- Classification: max = largest count. If max < MIN_COUNT → 00. If two or more channels share max → 00 (ambiguous). Otherwise the unique max channel gives 01 red, 11 green, 10 blue.
- Latency: color/color_valid update 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles after leaving IDLE. Back-to-back measurements follow with the same period.
- enable dropped mid-measurement: abort to IDLE next cycle; no color_valid; color and debug counts keep their previous values.
- Reset mid-measurement: immediate return to reset values; no pulse.
- Counter saturation: a count stuck at max still takes part in the comparison normally.
- color_valid pulses on every completed measurement, including 00 results.

Test Plan (GATE_CYCLES=100, SETTLE_CYCLES=10, MIN_COUNT=5):
- Reset: rst_n low with sensor toggling → color=00, valid=0, s0=1, s1=0, s2,s3=00, and they stay so while rst_n is low.
- Red dominant: sensor period 4 clk under red filter, 10 under green, 20 under blue; enable high → red_cnt≈25, green≈10, blue≈5. color=01, valid pulse exactly once at cycle 331 after leaving IDLE.
- Green dominant (period 4 under green, others 20) → color=11. Blue dominant (period 4 under blue) → color=10. Check s2,s3 sequence 00→11→01 across the gates.
- Weak/tie: sensor period 40 on all filters (count 2–3) → 00 with valid pulse. Equal period 5 on red and green, 20 on blue → 00.
- Abort: drop enable during GATE_G → IDLE next cycle, no valid pulse, color keeps the prior 01. Re-assert → full new measurement of 331 cycles.
- Saturation: CNT_W=4 with period 2 on red → red_cnt=15 saturates, color=01.
